// File: rtl/microwave_controller.sv
// Oven sequencer: keypad digit entry into the timer, cook/pause/done control,
// countdown tick generation, magnetron enable and completion alert.
module microwave_controller #(
    parameter int TICK_DIV    = 100,
    parameter int DONE_CYCLES = 50,
    parameter int DIGITS      = 3
) (
    input  logic       CLK,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_done,
    output logic [3:0] timer_digit,
    output logic       timer_loadn,
    output logic       timer_clearn,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       done_alert,
    output logic [2:0] state_out
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DONE_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_CYCLES - 1);
    localparam logic [2:0]    DIGIT_MAX = 3'(DIGITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [2:0]      digit_count, digit_count_next;
    logic [TW-1:0]   tick_cnt, tick_cnt_next;
    logic [DW-1:0]   done_cnt, done_cnt_next;
    logic            stop_prev;
    logic            key_ok;
    logic            take_key;
    logic            clear_timer;
    logic            stop_rise;

    always_comb begin
        state_next       = state;
        digit_count_next = digit_count;
        tick_cnt_next    = tick_cnt;
        done_cnt_next    = done_cnt;
        take_key         = 1'b0;
        clear_timer      = 1'b0;
        key_ok           = key_valid && (key_digit <= 4'd9) && (digit_count < DIGIT_MAX);
        stop_rise        = stop && !stop_prev;

        case (state)
            IDLE: begin
                if (key_ok) begin
                    take_key   = 1'b1;
                    state_next = ENTRY;
                end
            end

            ENTRY: begin
                if (stop) begin
                    clear_timer      = 1'b1;
                    digit_count_next = 3'd0;
                    state_next       = IDLE;
                end else if (start && door_closed && !timer_done) begin
                    tick_cnt_next = '0;
                    state_next    = COOK;
                end else if (key_ok) begin
                    take_key = 1'b1;
                end
            end

            // The exit cycle still counts as cooked time, so the counter
            // advances on every COOK edge and a resume never double-ticks.
            COOK: begin
                tick_cnt_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
                if (timer_done) begin
                    done_cnt_next = '0;
                    state_next    = DONE;
                end else if (!door_closed || stop) begin
                    state_next = PAUSE;
                end
            end

            // Only a fresh stop press clears; a stop still held from COOK does not.
            PAUSE: begin
                if (stop_rise) begin
                    clear_timer      = 1'b1;
                    digit_count_next = 3'd0;
                    tick_cnt_next    = '0;
                    state_next       = IDLE;
                end else if (start && door_closed) begin
                    state_next = COOK;
                end
            end

            DONE: begin
                if (stop || (done_cnt == DONE_LAST)) begin
                    clear_timer      = 1'b1;
                    digit_count_next = 3'd0;
                    tick_cnt_next    = '0;
                    state_next       = IDLE;
                end else begin
                    done_cnt_next = done_cnt + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase

        if (take_key) begin
            digit_count_next = digit_count + 3'd1;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            digit_count  <= 3'd0;
            tick_cnt     <= '0;
            done_cnt     <= '0;
            stop_prev    <= 1'b0;
            timer_digit  <= 4'd0;
            timer_loadn  <= 1'b1;
            timer_clearn <= 1'b0;
            timer_enable <= 1'b0;
            mag_on       <= 1'b0;
            done_alert   <= 1'b0;
        end else begin
            state        <= state_next;
            digit_count  <= digit_count_next;
            tick_cnt     <= tick_cnt_next;
            done_cnt     <= done_cnt_next;
            stop_prev    <= stop;
            timer_digit  <= take_key ? key_digit : 4'd0;
            timer_loadn  <= !take_key;
            timer_clearn <= !clear_timer;
            timer_enable <= (state_next == COOK) && (tick_cnt_next == TICK_LAST);
            mag_on       <= (state_next == COOK);
            done_alert   <= (state_next == DONE);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller with a behavioural min:ss timer
// attached to its timer interface.
module tb_microwave_controller;

    logic       CLK = 1'b0;
    logic       clear = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic       timer_done;
    logic [3:0] timer_digit;
    logic       timer_loadn;
    logic       timer_clearn;
    logic       timer_enable;
    logic       mag_on;
    logic       done_alert;
    logic [2:0] state_out;

    int errors = 0;
    int checks = 0;

    logic [3:0] tm_min = 4'd0;
    logic [3:0] tm_tens = 4'd0;
    logic [3:0] tm_sec = 4'd0;
    logic [11:0] tm_all;
    logic        exp_en;

    microwave_controller #(
        .TICK_DIV   (4),
        .DONE_CYCLES(6),
        .DIGITS     (3)
    ) dut (
        .CLK         (CLK),
        .clear       (clear),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .timer_done  (timer_done),
        .timer_digit (timer_digit),
        .timer_loadn (timer_loadn),
        .timer_clearn(timer_clearn),
        .timer_enable(timer_enable),
        .mag_on      (mag_on),
        .done_alert  (done_alert),
        .state_out   (state_out)
    );

    always #5 CLK = ~CLK;

    // Timer model: shift-in on loadn, decimal min:ss countdown on enable.
    always @(posedge CLK) begin
        if (!timer_clearn) begin
            tm_min  <= 4'd0;
            tm_tens <= 4'd0;
            tm_sec  <= 4'd0;
        end else if (!timer_loadn) begin
            tm_min  <= tm_tens;
            tm_tens <= tm_sec;
            tm_sec  <= timer_digit;
        end else if (timer_enable && !timer_done) begin
            if (tm_sec != 4'd0) begin
                tm_sec <= tm_sec - 4'd1;
            end else begin
                tm_sec <= 4'd9;
                if (tm_tens != 4'd0) begin
                    tm_tens <= tm_tens - 4'd1;
                end else begin
                    tm_tens <= 4'd5;
                    tm_min  <= tm_min - 4'd1;
                end
            end
        end
    end

    assign timer_done = (tm_min == 4'd0) && (tm_tens == 4'd0) && (tm_sec == 4'd0);
    assign tm_all     = {tm_min, tm_tens, tm_sec};

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge CLK);
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic test_reset;
        #1 clear = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (timer_clearn !== 1'b0) begin errors++; $display("[TB] FAIL reset_clearn: got %0b expected 0", timer_clearn); end
        checks++; if (timer_loadn !== 1'b1) begin errors++; $display("[TB] FAIL reset_loadn: got %0b expected 1", timer_loadn); end
        checks++; if ({timer_enable, mag_on, done_alert} !== 3'b000) begin errors++; $display("[TB] FAIL reset_en_mag_alert: got %b expected 000", {timer_enable, mag_on, done_alert}); end
        checks++; if (timer_digit !== 4'd0) begin errors++; $display("[TB] FAIL reset_digit: got %0d expected 0", timer_digit); end
        checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_out); end
        clear = 1'b0;
        @(negedge CLK);
        checks++; if (timer_clearn !== 1'b1) begin errors++; $display("[TB] FAIL reset_clearn_release: got %0b expected 1", timer_clearn); end
        checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_state_release: got %0d expected 0", state_out); end
    endtask

    task automatic test_entry;
        press_key(4'd2);
        checks++; if ({timer_loadn, timer_digit} !== {1'b0, 4'd2}) begin errors++; $display("[TB] FAIL entry_key2: got loadn=%0b digit=%0d expected loadn=0 digit=2", timer_loadn, timer_digit); end
        checks++; if (state_out !== 3'd1) begin errors++; $display("[TB] FAIL entry_state: got %0d expected 1", state_out); end
        @(negedge CLK);
        checks++; if (timer_loadn !== 1'b1) begin errors++; $display("[TB] FAIL entry_strobe_width: got %0b expected 1", timer_loadn); end
        press_key(4'd1);
        checks++; if ({timer_loadn, timer_digit} !== {1'b0, 4'd1}) begin errors++; $display("[TB] FAIL entry_key1: got loadn=%0b digit=%0d expected loadn=0 digit=1", timer_loadn, timer_digit); end
        @(negedge CLK);
        press_key(4'd7);
        checks++; if ({timer_loadn, timer_digit} !== {1'b0, 4'd7}) begin errors++; $display("[TB] FAIL entry_key7: got loadn=%0b digit=%0d expected loadn=0 digit=7", timer_loadn, timer_digit); end
        @(negedge CLK);
        press_key(4'd9);
        checks++; if (timer_loadn !== 1'b1) begin errors++; $display("[TB] FAIL entry_fourth_key: got loadn=%0b expected 1", timer_loadn); end
        @(negedge CLK);
        checks++; if (tm_all !== 12'h217) begin errors++; $display("[TB] FAIL entry_timer_value: got %h expected 217", tm_all); end
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL entry_stop_state: got %0d expected 0", state_out); end
        checks++; if (timer_clearn !== 1'b0) begin errors++; $display("[TB] FAIL entry_stop_clearn: got %0b expected 0", timer_clearn); end
        @(negedge CLK);
        checks++; if (timer_clearn !== 1'b1) begin errors++; $display("[TB] FAIL entry_stop_clearn_width: got %0b expected 1", timer_clearn); end
        checks++; if (tm_all !== 12'h000) begin errors++; $display("[TB] FAIL entry_stop_cleared: got %h expected 000", tm_all); end
    endtask

    task automatic test_cook_done;
        press_key(4'd5);
        checks++; if ({timer_loadn, timer_digit} !== {1'b0, 4'd5}) begin errors++; $display("[TB] FAIL cook_key5: got loadn=%0b digit=%0d expected loadn=0 digit=5", timer_loadn, timer_digit); end
        @(negedge CLK);
        checks++; if (tm_all !== 12'h005) begin errors++; $display("[TB] FAIL cook_timer_load: got %h expected 005", tm_all); end
        door_closed = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge CLK);
            start = 1'b0;
            exp_en = (i % 4 == 0);
            checks++; if (timer_enable !== exp_en) begin errors++; $display("[TB] FAIL cook_tick_c%0d: got %0b expected %0b", i, timer_enable, exp_en); end
            checks++; if ({mag_on, state_out} !== {1'b1, 3'd2}) begin errors++; $display("[TB] FAIL cook_mag_c%0d: got mag=%0b state=%0d expected mag=1 state=2", i, mag_on, state_out); end
        end
        checks++; if (tm_all !== 12'h000) begin errors++; $display("[TB] FAIL cook_timer_expired: got %h expected 000", tm_all); end
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checks++; if ({done_alert, mag_on, state_out} !== {1'b1, 1'b0, 3'd4}) begin errors++; $display("[TB] FAIL done_c%0d: got alert=%0b mag=%0b state=%0d expected alert=1 mag=0 state=4", i, done_alert, mag_on, state_out); end
        end
        @(negedge CLK);
        checks++; if ({done_alert, state_out, timer_clearn} !== {1'b0, 3'd0, 1'b0}) begin errors++; $display("[TB] FAIL done_exit: got alert=%0b state=%0d clearn=%0b expected alert=0 state=0 clearn=0", done_alert, state_out, timer_clearn); end
        @(negedge CLK);
        checks++; if (timer_clearn !== 1'b1) begin errors++; $display("[TB] FAIL done_clearn_width: got %0b expected 1", timer_clearn); end
    endtask

    task automatic test_pause_resume;
        press_key(4'd1);
        @(negedge CLK);
        press_key(4'd0);
        @(negedge CLK);
        press_key(4'd0);
        @(negedge CLK);
        checks++; if (tm_all !== 12'h100) begin errors++; $display("[TB] FAIL pause_timer_load: got %h expected 100", tm_all); end
        start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            start = 1'b0;
            exp_en = (i == 4);
            checks++; if (timer_enable !== exp_en) begin errors++; $display("[TB] FAIL pause_pre_tick_c%0d: got %0b expected %0b", i, timer_enable, exp_en); end
        end
        door_closed = 1'b0;
        @(negedge CLK);
        checks++; if ({state_out, mag_on} !== {3'd3, 1'b0}) begin errors++; $display("[TB] FAIL pause_door_open: got state=%0d mag=%0b expected state=3 mag=0", state_out, mag_on); end
        repeat (3) begin
            @(negedge CLK);
            checks++; if ({timer_enable, mag_on, state_out} !== {1'b0, 1'b0, 3'd3}) begin errors++; $display("[TB] FAIL pause_hold: got en=%0b mag=%0b state=%0d expected en=0 mag=0 state=3", timer_enable, mag_on, state_out); end
        end
        checks++; if (tm_all !== 12'h059) begin errors++; $display("[TB] FAIL pause_timer_borrow: got %h expected 059", tm_all); end
        door_closed = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++; if ({state_out, mag_on, timer_enable} !== {3'd2, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL resume_first: got state=%0d mag=%0b en=%0b expected state=2 mag=1 en=0", state_out, mag_on, timer_enable); end
        @(negedge CLK);
        checks++; if (timer_enable !== 1'b1) begin errors++; $display("[TB] FAIL resume_residual_tick: got %0b expected 1", timer_enable); end
        @(negedge CLK);
        checks++; if (timer_enable !== 1'b0) begin errors++; $display("[TB] FAIL resume_tick_width: got %0b expected 0", timer_enable); end
        stop = 1'b1;
        @(negedge CLK);
        checks++; if ({state_out, mag_on} !== {3'd3, 1'b0}) begin errors++; $display("[TB] FAIL stop_cook_pause: got state=%0d mag=%0b expected state=3 mag=0", state_out, mag_on); end
        repeat (2) @(negedge CLK);
        checks++; if (state_out !== 3'd3) begin errors++; $display("[TB] FAIL stop_held_no_clear: got %0d expected 3", state_out); end
        checks++; if (tm_all !== 12'h058) begin errors++; $display("[TB] FAIL stop_held_timer: got %h expected 058", tm_all); end
        stop = 1'b0;
        @(negedge CLK);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        checks++; if ({state_out, timer_clearn} !== {3'd0, 1'b0}) begin errors++; $display("[TB] FAIL stop_pause_clear: got state=%0d clearn=%0b expected state=0 clearn=0", state_out, timer_clearn); end
        @(negedge CLK);
        checks++; if ({timer_clearn, tm_all} !== {1'b1, 12'h000}) begin errors++; $display("[TB] FAIL stop_pause_cleared: got clearn=%0b timer=%h expected clearn=1 timer=000", timer_clearn, tm_all); end
    endtask

    task automatic test_edge_cases;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL edge_idle_start: got %0d expected 0", state_out); end
        press_key(4'd12);
        checks++; if ({timer_loadn, state_out} !== {1'b1, 3'd0}) begin errors++; $display("[TB] FAIL edge_bad_digit: got loadn=%0b state=%0d expected loadn=1 state=0", timer_loadn, state_out); end
        @(negedge CLK);
        press_key(4'd0);
        checks++; if ({timer_loadn, timer_digit, state_out} !== {1'b0, 4'd0, 3'd1}) begin errors++; $display("[TB] FAIL edge_zero_key: got loadn=%0b digit=%0d state=%0d expected loadn=0 digit=0 state=1", timer_loadn, timer_digit, state_out); end
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++; if ({state_out, mag_on} !== {3'd1, 1'b0}) begin errors++; $display("[TB] FAIL edge_start_zero_entry: got state=%0d mag=%0b expected state=1 mag=0", state_out, mag_on); end
        press_key(4'd3);
        @(negedge CLK);
        door_closed = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        door_closed = 1'b1;
        checks++; if ({state_out, mag_on} !== {3'd1, 1'b0}) begin errors++; $display("[TB] FAIL edge_start_door_open: got state=%0d mag=%0b expected state=1 mag=0", state_out, mag_on); end
        key_valid = 1'b1;
        key_digit = 4'd4;
        stop = 1'b1;
        @(negedge CLK);
        key_valid = 1'b0;
        stop = 1'b0;
        checks++; if ({state_out, timer_loadn, timer_clearn} !== {3'd0, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL edge_key_with_stop: got state=%0d loadn=%0b clearn=%0b expected state=0 loadn=1 clearn=0", state_out, timer_loadn, timer_clearn); end
        @(negedge CLK);
        press_key(4'd1);
        @(negedge CLK);
        start = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            start = 1'b0;
        end
        checks++; if (timer_enable !== 1'b1) begin errors++; $display("[TB] FAIL edge_last_tick: got %0b expected 1", timer_enable); end
        @(negedge CLK);
        door_closed = 1'b0;
        @(negedge CLK);
        checks++; if ({state_out, mag_on, done_alert} !== {3'd4, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL edge_done_and_door: got state=%0d mag=%0b alert=%0b expected state=4 mag=0 alert=1", state_out, mag_on, done_alert); end
        repeat (2) begin
            @(negedge CLK);
            checks++; if ({state_out, mag_on} !== {3'd4, 1'b0}) begin errors++; $display("[TB] FAIL edge_done_mag_off: got state=%0d mag=%0b expected state=4 mag=0", state_out, mag_on); end
        end
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        door_closed = 1'b1;
        checks++; if ({state_out, done_alert, timer_clearn} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL edge_done_stop: got state=%0d alert=%0b clearn=%0b expected state=0 alert=0 clearn=0", state_out, done_alert, timer_clearn); end
        @(negedge CLK);
    endtask

    task automatic test_clear_mid_cook;
        press_key(4'd4);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++; if ({state_out, mag_on} !== {3'd2, 1'b1}) begin errors++; $display("[TB] FAIL clear_cook_entry: got state=%0d mag=%0b expected state=2 mag=1", state_out, mag_on); end
        #2 clear = 1'b1;
        #1;
        checks++; if ({mag_on, state_out, timer_clearn} !== {1'b0, 3'd0, 1'b0}) begin errors++; $display("[TB] FAIL clear_async: got mag=%0b state=%0d clearn=%0b expected mag=0 state=0 clearn=0", mag_on, state_out, timer_clearn); end
        @(negedge CLK);
        checks++; if (tm_all !== 12'h000) begin errors++; $display("[TB] FAIL clear_timer_cleared: got %h expected 000", tm_all); end
        clear = 1'b0;
        @(negedge CLK);
        checks++; if ({timer_clearn, state_out} !== {1'b1, 3'd0}) begin errors++; $display("[TB] FAIL clear_release: got clearn=%0b state=%0d expected clearn=1 state=0", timer_clearn, state_out); end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_cook_done();
        test_pause_resume();
        test_edge_cases();
        test_clear_mid_cook();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
